pes_sipo_deser: RTL
===================

PES_SIPO_DESER -- requirements
Module: pes_sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, is the deserialised word width; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 1, selects the serial bit order (1: the first bit received lands in bit 0; 0: the first bit received lands in bit WIDTH-1).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclr  input  1  synchronous abort of the partial word; also clears overrun.
REQ-006 in_valid  input  1  in_bit is sampled on this edge.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 out_data  output  WIDTH  completed parallel word (holding register).
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-011 overrun  output  1  sticky; a completed word was dropped.
REQ-012 bit_cnt  output  $clog2(WIDTH+1)  number of bits in the current partial word.

Function
REQ-013 A bit SHALL be shifted into the shift register on each edge with in_valid=1 and sclr=0; with in_valid=0 the shift register and bit_cnt SHALL hold.
REQ-014 LSB_FIRST=1: shift right, new bit enters bit WIDTH-1; LSB_FIRST=0: shift left, new bit enters bit 0.
REQ-015 bit_cnt SHALL increment per accepted bit and wrap from WIDTH-1 to 0 on the edge that accepts the WIDTH-th bit (word completion).
REQ-016 On completion, the full word (including the bit accepted on that edge) SHALL be loaded into out_data with out_valid=1 visible after that same edge (latency 0 cycles after the last bit edge).
REQ-017 Handshake: the word is consumed on an edge with out_valid=1 and out_ready=1; out_valid SHALL then clear unless a new word completes on the same edge.
REQ-018 out_data SHALL remain stable while out_valid=1 and not consumed.
REQ-019 Completion with out_valid=1 and out_ready=0: the new word SHALL be dropped, out_data kept, overrun set; bit_cnt still wraps to 0.
REQ-020 Completion with out_valid=1 and out_ready=1 on the same edge: the old word is consumed, the new word is loaded, out_valid stays 1, and overrun is not set.
REQ-021 overrun SHALL stay 1 until rst or sclr.
REQ-022 sclr=1: bit_cnt=0, shift register=0, overrun=0, and in_bit is ignored that edge; out_data/out_valid are unaffected, and a consume on that edge SHALL still occur.
REQ-023 Completion loads out_data only; the shift register need not be cleared, since bit_cnt alone frames words.

Reset
REQ-024 rst=1 SHALL set shift register=0, bit_cnt=0, out_data=0, out_valid=0, overrun=0 on the next edge, overriding sclr, in_valid and out_ready.
REQ-025 rst asserted mid-word SHALL discard the partial word; the first bit after rst deasserts starts a new word at bit_cnt=0.

Structure
REQ-026 Package pes_sipo_pkg SHALL hold the WIDTH and LSB_FIRST defaults and a function computing the bit_cnt width.
REQ-027 Sub-module pes_shift_reg (parameters WIDTH, LSB_FIRST; ports clk, rst, clr, en, d, q) SHALL implement the shift register; pes_sipo_deser adds counter, holding register and handshake.
REQ-028 No latches, no multiple clocks, and no combinational path from in_bit to any output.

Verification
REQ-029 WIDTH=8, LSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive edges with out_ready=1 -> out_data=0x4D, out_valid=1 for exactly 1 cycle, overrun=0.
REQ-030 Same stream, LSB_FIRST=0 -> out_data=0xB2.
REQ-031 out_ready=0, two full words 0x4D then 0x11 -> out_data stays 0x4D, overrun=1 after the 16th bit, bit_cnt=0.
REQ-032 out_ready pulsed on the edge completing the 2nd word -> out_data=0x11, out_valid remains 1, overrun=0.
REQ-033 Three bits, then sclr, then 8 bits 0xFF -> out_data=0xFF; the aborted bits have no effect.
REQ-034 rst asserted after 5 bits with out_valid=1 -> all outputs 0 on the next edge; the next 8 bits form a correct word.

Source files
------------

// File: rtl/pes_sipo_pkg.sv
// Shared defaults and width helper for the serial-in / parallel-out deserialiser.
package pes_sipo_pkg;
  localparam int WIDTH_DEF     = 8;
  localparam bit LSB_FIRST_DEF = 1'b1;

  // bit_cnt must be able to represent 0..WIDTH
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/pes_sipo_deser_if.sv
// Serial input, word output and status bundle for pes_sipo_deser.
interface pes_sipo_deser_if
  import pes_sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  localparam int CW = cnt_w(WIDTH);

  logic             sclr;
  logic             in_valid;
  logic             in_bit;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output sclr, in_valid, in_bit, out_ready,
    input  out_data, out_valid, overrun, bit_cnt
  );

  modport slave (
    input  sclr, in_valid, in_bit, out_ready,
    output out_data, out_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/pes_shift_reg.sv
// Serial shift register; direction chosen so the first bit in ends at bit 0
// (LSB_FIRST=1) or at bit WIDTH-1 (LSB_FIRST=0) after WIDTH shifts.
module pes_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);
  generate
    if (LSB_FIRST) begin : g_right
      always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en)    q <= {d, q[WIDTH-1:1]};
      end
    end else begin : g_left
      always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en)    q <= {q[WIDTH-2:0], d};
      end
    end
  endgenerate
endmodule

// File: rtl/pes_sipo_deser.sv
// Deserialiser: frames WIDTH-bit words with a bit counter and offers each
// completed word through a one-entry valid/ready holding register.
module pes_sipo_deser
  import pes_sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LSB_FIRST = LSB_FIRST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pes_sipo_deser_if.slave   bus
);
  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] word_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ovr;
  logic             accept;
  logic             complete;
  logic             consume;

  assign accept   = bus.in_valid && !bus.sclr;
  assign complete = accept && (cnt == CW'(WIDTH - 1));
  assign consume  = valid && bus.out_ready;

  pes_shift_reg #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_sr (
    .clk (clk),
    .rst (rst),
    .clr (bus.sclr),
    .en  (accept),
    .d   (bus.in_bit),
    .q   (sr_q)
  );

  // The completing bit is not in sr_q yet, so build the word it finishes here.
  generate
    if (LSB_FIRST) begin : g_word_r
      assign word_nxt = {bus.in_bit, sr_q[WIDTH-1:1]};
    end else begin : g_word_l
      assign word_nxt = {sr_q[WIDTH-2:0], bus.in_bit};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)           cnt <= '0;
    else if (bus.sclr) cnt <= '0;
    else if (complete) cnt <= '0;
    else if (accept)   cnt <= cnt + CW'(1);
  end

  // A completed word may land only if the slot is empty or drains this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (complete && (!valid || bus.out_ready)) begin
      data  <= word_nxt;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                     ovr <= 1'b0;
    else if (bus.sclr)                           ovr <= 1'b0;
    else if (complete && valid && !bus.out_ready) ovr <= 1'b1;
  end

  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.overrun   = ovr;
  assign bus.bit_cnt   = cnt;
endmodule
